// File: rtl/adder_seq_pkg.sv
// Shared types for the limb-sequenced adder: FSM states and operation select.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } seq_op_t;

endpackage

// File: rtl/fulladder_chain.sv
// WIDTH-bit ripple-carry full-adder chain; purely combinational, shared across limbs.
module fulladder_chain #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum_c,
    output logic             carry_out_c
);

    logic c;

    always_comb begin
        sum_c = '0;
        c     = carry_in;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out_c = c;
    end

endmodule

// File: rtl/multilimb_adder_seq.sv
// Adds or subtracts TOTAL-bit operands one WIDTH-bit limb per clock through a
// single shared fulladder_chain, LSB limb first, with a registered inter-limb carry.
module multilimb_adder_seq
    import adder_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned LIMBS = 4,
    localparam int unsigned TOTAL = WIDTH * LIMBS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [TOTAL-1:0] in_a,
    input  logic [TOTAL-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOTAL-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TOTAL-1:0] a_q, a_d;
    logic [TOTAL-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [TOTAL-1:0] sum_q, sum_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] a_limb, b_limb, chain_sum;
    logic             chain_cout;
    logic             msb_cin;

    // Select the current limb of each operand for the shared chain.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int unsigned i = 0; i < LIMBS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                a_limb = a_q[i*WIDTH +: WIDTH];
                b_limb = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    fulladder_chain #(.WIDTH(WIDTH)) u_chain (
        .a          (a_limb),
        .b          (b_limb),
        .carry_in   (carry_q),
        .sum_c      (chain_sum),
        .carry_out_c(chain_cout)
    );

    // Carry into the sign bit, recovered from the top limb's operand and sum bits.
    assign msb_cin = a_limb[WIDTH-1] ^ b_limb[WIDTH-1] ^ chain_sum[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = (seq_op_t'(in_sub) == OP_SUB) ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < LIMBS; i++) begin
                    if (IDX_W'(i) == idx_q) begin
                        sum_d[i*WIDTH +: WIDTH] = chain_sum;
                    end
                end
                carry_d = chain_cout;
                if (idx_q == LAST_IDX) begin
                    out_carry_d = chain_cout;
                    out_ovf_d   = msb_cin ^ chain_cout;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_multilimb_adder_seq.sv
// Bench for multilimb_adder_seq: directed corner cases plus randomized streaming on
// a 4-limb and a 1-limb instance, checked against a plain-arithmetic reference.
module tb_multilimb_adder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sub, out_ready;
    logic [31:0] in_a, in_b;
    logic        in_ready, out_valid, out_carry, out_ovf;
    logic [31:0] out_sum;

    logic        in_valid1, in_sub1, out_ready1;
    logic [7:0]  in_a1, in_b1;
    logic        in_ready1, out_valid1, out_carry1, out_ovf1;
    logic [7:0]  out_sum1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multilimb_adder_seq #(.WIDTH(8), .LIMBS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    multilimb_adder_seq #(.WIDTH(8), .LIMBS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_sub(in_sub1),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_carry(out_carry1), .out_ovf(out_ovf1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: n-bit modular add/sub, carry out, signed overflow from sign rules.
    task automatic ref_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input int unsigned n, output logic [63:0] s,
                          output logic c, output logic o);
        logic [63:0] mask, aa, bb, r;
        mask = (64'd1 << n) - 64'd1;
        aa   = a & mask;
        bb   = sub ? (~b & mask) : (b & mask);
        r    = aa + bb + 64'(sub);
        c    = r[n];
        s    = r & mask;
        if (sub) o = (a[n-1] != b[n-1]) && (s[n-1] != a[n-1]);
        else     o = (a[n-1] == b[n-1]) && (s[n-1] != a[n-1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input bit keep);
        int lat;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_sub = ~sub;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd4);
        check("sum", 64'(out_sum), 64'(es));
        check("carry", 64'(out_carry), 64'(ec));
        check("ovf", 64'(out_ovf), 64'(eo));
        if (!keep) cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] s;
        logic        c, o;
        logic [33:0] q0[$];
        logic [9:0]  q1[$];
        logic [33:0] e0;
        logic [9:0]  e1;
        logic [31:0] hs;
        logic        hc, ho;
        int last0, last1, n0, n1, seen;

        rst_n = 1'b0;
        in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_sub1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        do_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        do_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Back-pressure: result must hold and new requests must be dropped.
        out_ready = 1'b0;
        do_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 1'b1);
        hs = out_sum; hc = out_carry; ho = out_ovf;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k == 3);
            in_a = 32'hDEADBEEF;
            in_b = 32'h11111111;
            cyc();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sum", 64'(out_sum), 64'(hs));
            check("hold_flags", 64'({out_carry, out_ovf}), 64'({hc, ho}));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("release_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (out_valid) seen++;
        end
        check("ignored_request", 64'(seen), 64'd0);

        // Reset during the second RUN cycle aborts the operation.
        in_valid = 1'b1; in_sub = 1'b0; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        cyc();
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        do_op(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);

        // Streaming with handshakes tied high on both instances.
        in_valid = 1'b1; out_ready = 1'b1;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        last0 = -1; last1 = -1; n0 = 0; n1 = 0;
        for (int t = 0; t < 150; t++) begin
            if (out_valid) begin
                if (q0.size() == 0) check("stream0_unexpected", 64'd1, 64'd0);
                else begin
                    e0 = q0.pop_front();
                    check("stream0_result", 64'({out_ovf, out_carry, out_sum}), 64'(e0));
                end
                if (last0 >= 0) check("stream0_period", 64'(t - last0), 64'd6);
                last0 = t;
                n0++;
            end
            if (out_valid1) begin
                if (q1.size() == 0) check("stream1_unexpected", 64'd1, 64'd0);
                else begin
                    e1 = q1.pop_front();
                    check("stream1_result", 64'({out_ovf1, out_carry1, out_sum1}), 64'(e1));
                end
                if (last1 >= 0) check("stream1_period", 64'(t - last1), 64'd3);
                last1 = t;
                n1++;
            end
            if (in_ready) begin
                in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
                ref_op(64'(in_a), 64'(in_b), in_sub, 32, s, c, o);
                q0.push_back({o, c, s[31:0]});
            end
            if (in_ready1) begin
                in_a1 = 8'($urandom); in_b1 = 8'($urandom); in_sub1 = 1'($urandom_range(0, 1));
                ref_op(64'(in_a1), 64'(in_b1), in_sub1, 8, s, c, o);
                q1.push_back({o, c, s[7:0]});
            end
            cyc();
        end
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        check("stream0_count", 64'(n0 >= 20), 64'd1);
        check("stream1_count", 64'(n1 >= 40), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
